// File: rtl/tinyriscv_pkg.sv
// Shared core types and constants.
// Fetch/decode bus widths and the canonical NOP encoding.
package tinyriscv_pkg;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  localparam InstBus INST_NOP = 32'h0000_0013;

  typedef struct packed {
    InstAddrBus addr;
    InstBus     inst;
  } if_entry_t;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch -> buffer valid/ready handshake bundle.
// master = fetch unit, slave = if_id_buf.
interface if_id_buf_if;
  import tinyriscv_pkg::*;

  logic       fetch_valid_i;
  logic       fetch_ready_o;
  InstBus     fetch_inst_i;
  InstAddrBus fetch_addr_i;

  modport master (
    output fetch_valid_i,
    output fetch_inst_i,
    output fetch_addr_i,
    input  fetch_ready_o
  );

  modport slave (
    input  fetch_valid_i,
    input  fetch_inst_i,
    input  fetch_addr_i,
    output fetch_ready_o
  );

endinterface

// File: rtl/if_id_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush.
// Registered write, combinational head read.
module if_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset, count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and count; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full && !flush)
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty && !flush)
  );

  a_cnt_range: assert property (
    @(posedge clk) disable iff (rst) cnt <= FULL_CNT
  );

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode buffer: FIFO, flush gating, NOP on empty.
// Optional stats counters under IF_ID_BUF_STATS_EN.
module if_id_buf
  import tinyriscv_pkg::*;
#(
  parameter int     DEPTH    = 2,
  parameter InstBus NOP_INST = INST_NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  if_id_buf_if.slave                 fetch,
  input  logic                       ex_jump_flag_i,
  input  logic                       hold_i,
  output InstBus                     inst_o,
  output InstAddrBus                 inst_addr_o,
  output logic                       inst_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
`ifdef IF_ID_BUF_STATS_EN
  ,
  output logic [15:0]                flush_cnt_o,
  output logic [15:0]                bubble_cnt_o
`endif
);

  if_entry_t wr_entry;
  if_entry_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;

  assign wr_entry.inst = fetch.fetch_inst_i;
  assign wr_entry.addr = fetch.fetch_addr_i;

  assign fetch.fetch_ready_o = !full;

  assign push = fetch.fetch_valid_i && !full && !ex_jump_flag_i;
  assign pop  = inst_valid_o && !hold_i && !ex_jump_flag_i;

  if_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(if_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (ex_jump_flag_i),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (occupancy_o),
    .full  (full),
    .empty (empty)
  );

  // Empty buffer presents a harmless NOP at address 0.
  always_comb begin
    inst_valid_o = !empty;
    inst_o       = NOP_INST;
    inst_addr_o  = '0;
    if (!empty) begin
      inst_o      = head.inst;
      inst_addr_o = head.addr;
    end
  end

`ifdef IF_ID_BUF_STATS_EN
  // Saturating flush and bubble event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (ex_jump_flag_i && flush_cnt_o != 16'hFFFF) begin
        flush_cnt_o <= flush_cnt_o + 16'd1;
      end
      if (!inst_valid_o && !hold_i && !ex_jump_flag_i
          && bubble_cnt_o != 16'hFFFF) begin
        bubble_cnt_o <= bubble_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Directed testbench for if_id_buf.
// Define IF_ID_BUF_STATS_EN to also check the stats counters.
module tb_if_id_buf;
  import tinyriscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_jump_flag_i;
  logic        hold_i;
  InstBus      inst_o;
  InstAddrBus  inst_addr_o;
  logic        inst_valid_o;
  logic [1:0]  occupancy_o;
`ifdef IF_ID_BUF_STATS_EN
  logic [15:0] flush_cnt_o;
  logic [15:0] bubble_cnt_o;
`endif

  int n_run;
  int n_fail;

  if_id_buf_if fif ();

  if_id_buf #(
    .DEPTH    (2),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch          (fif),
    .ex_jump_flag_i (ex_jump_flag_i),
    .hold_i         (hold_i),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_valid_o   (inst_valid_o),
    .occupancy_o    (occupancy_o)
`ifdef IF_ID_BUF_STATS_EN
    ,
    .flush_cnt_o    (flush_cnt_o),
    .bubble_cnt_o   (bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.fetch_valid_i = 1'b0;
    fif.fetch_inst_i  = '0;
    fif.fetch_addr_i  = '0;
    ex_jump_flag_i    = 1'b0;
    hold_i            = 1'b0;
  endtask

  task automatic offer(input InstBus i, input InstAddrBus a);
    fif.fetch_valid_i = 1'b1;
    fif.fetch_inst_i  = i;
    fif.fetch_addr_i  = a;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %0b want 0", inst_valid_o);
    end
    n_run++;
    if (inst_o !== 32'h13) begin
      n_fail++;
      $display("FAIL reset_inst got %h want 00000013", inst_o);
    end
    n_run++;
    if (inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr got %h want 0", inst_addr_o);
    end
    n_run++;
    if (fif.fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %0b want 1", fif.fetch_ready_o);
    end
    n_run++;
    if (occupancy_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_occ got %0d want 0", occupancy_o);
    end
  endtask

  task automatic test_single();
    offer(32'h0050_0093, 32'h100);
    tick();
    idle_inputs();
    n_run++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0093
        || inst_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL single_head got v=%0b %h@%h want 1 00500093@100",
               inst_valid_o, inst_o, inst_addr_o);
    end
    tick();
    n_run++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h13
        || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL single_drain got v=%0b %h@%h want 0 00000013@0",
               inst_valid_o, inst_o, inst_addr_o);
    end
  endtask

  task automatic test_fill_hold();
    hold_i = 1'b1;
    offer(32'hA000_0000, 32'h0);
    tick();
    offer(32'hA000_0004, 32'h4);
    tick();
    offer(32'hA000_0008, 32'h8);
    n_run++;
    if (fif.fetch_ready_o !== 1'b0 || occupancy_o !== 2'd2) begin
      n_fail++;
      $display("FAIL fill_full got rdy=%0b occ=%0d want 0 2",
               fif.fetch_ready_o, occupancy_o);
    end
    tick();
    n_run++;
    if (occupancy_o !== 2'd2 || inst_addr_o !== 32'h0
        || inst_o !== 32'hA000_0000) begin
      n_fail++;
      $display("FAIL fill_hold got occ=%0d %h@%h want 2 a0000000@0",
               occupancy_o, inst_o, inst_addr_o);
    end
    hold_i = 1'b0;
    tick();
    n_run++;
    if (inst_addr_o !== 32'h4 || occupancy_o !== 2'd1
        || fif.fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_rel1 got %h occ=%0d rdy=%0b want 4 1 1",
               inst_addr_o, occupancy_o, fif.fetch_ready_o);
    end
    tick();
    fif.fetch_valid_i = 1'b0;
    n_run++;
    if (inst_addr_o !== 32'h8 || inst_o !== 32'hA000_0008
        || occupancy_o !== 2'd1) begin
      n_fail++;
      $display("FAIL fill_rel2 got %h@%h occ=%0d want a0000008@8 1",
               inst_o, inst_addr_o, occupancy_o);
    end
    tick();
    n_run++;
    if (inst_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_fail++;
      $display("FAIL fill_drain got v=%0b occ=%0d want 0 0",
               inst_valid_o, occupancy_o);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    hold_i = 1'b1;
    offer(32'hB000_0010, 32'h10);
    tick();
    offer(32'hB000_0014, 32'h14);
    tick();
    hold_i = 1'b0;
    ex_jump_flag_i = 1'b1;
    offer(32'hB000_0020, 32'h20);
    tick();
    idle_inputs();
    n_run++;
    if (occupancy_o !== 2'd0 || inst_valid_o !== 1'b0
        || fif.fetch_ready_o !== 1'b1 || inst_o !== 32'h13) begin
      n_fail++;
      $display("FAIL flush_empty got occ=%0d v=%0b rdy=%0b %h want 0 0 1 13",
               occupancy_o, inst_valid_o, fif.fetch_ready_o, inst_o);
    end
    tick();
    n_run++;
    if (inst_valid_o !== 1'b0 || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_discard got v=%0b addr=%h want 0 0",
               inst_valid_o, inst_addr_o);
    end
  endtask

  task automatic test_flush_hold();
    hold_i = 1'b1;
    offer(32'hC000_0030, 32'h30);
    tick();
    fif.fetch_valid_i = 1'b0;
    n_run++;
    if (occupancy_o !== 2'd1 || inst_addr_o !== 32'h30) begin
      n_fail++;
      $display("FAIL fh_pre got occ=%0d addr=%h want 1 30",
               occupancy_o, inst_addr_o);
    end
    ex_jump_flag_i = 1'b1;
    tick();
    idle_inputs();
    n_run++;
    if (occupancy_o !== 2'd0 || inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fh_flush got occ=%0d v=%0b want 0 0",
               occupancy_o, inst_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    InstAddrBus a;
    for (int i = 0; i < 10; i++) begin
      a = 32'h200 + 32'(i * 4);
      offer(32'hD000_0000 | a, a);
      tick();
      n_run++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== a
          || inst_o !== (32'hD000_0000 | a) || occupancy_o !== 2'd1) begin
        n_fail++;
        $display("FAIL b2b_%0d got v=%0b %h@%h occ=%0d want 1 %h@%h 1",
                 i, inst_valid_o, inst_o, inst_addr_o, occupancy_o,
                 32'hD000_0000 | a, a);
      end
    end
    idle_inputs();
    tick();
    n_run++;
    if (inst_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_drain got v=%0b occ=%0d want 0 0",
               inst_valid_o, occupancy_o);
    end
  endtask

`ifdef IF_ID_BUF_STATS_EN
  task automatic test_stats();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (flush_cnt_o !== 16'd0 || bubble_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset got f=%0d b=%0d want 0 0",
               flush_cnt_o, bubble_cnt_o);
    end
    repeat (3) tick();
    ex_jump_flag_i = 1'b1;
    repeat (2) tick();
    ex_jump_flag_i = 1'b0;
    offer(32'hE000_0000, 32'h300);
    tick();
    fif.fetch_valid_i = 1'b0;
    tick();
    n_run++;
    if (flush_cnt_o !== 16'd2 || bubble_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL stats_count got f=%0d b=%0d want 2 4",
               flush_cnt_o, bubble_cnt_o);
    end
  endtask
`endif

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_hold();
    test_flush();
    test_flush_hold();
    test_back_to_back();
`ifdef IF_ID_BUF_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Fetch-to-decode boundary stage with a small instruction FIFO.
- Accepts instruction/address pairs from the fetch unit on a valid/ready handshake and buffers them.
- Presents the head entry to the decode stage and drops all buffered entries when execute redirects the PC.
- Feeds the decode stage's inst_i/inst_addr_i inputs and absorbs fetch latency while decode is held.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, >= 2.
- NOP_INST, 32'h0000_0013, instruction driven to decode when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- fetch_valid_i  input  1  fetch presents an instruction.
- fetch_ready_o  output  1  buffer can accept an instruction this cycle.
- fetch_inst_i  input  InstBus  fetched instruction.
- fetch_addr_i  input  InstAddrBus  address of the fetched instruction.
- ex_jump_flag_i  input  1  execute-stage redirect; flush.
- hold_i  input  1  decode/execute stall; head must not advance.
- inst_o  output  InstBus  instruction to decode.
- inst_addr_o  output  InstAddrBus  address to decode.
- inst_valid_o  output  1  inst_o/inst_addr_o hold a real buffered entry.
- occupancy_o  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=rd_ptr=0, count=0. Resulting outputs:
  - inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
  - fetch_ready_o=1, occupancy_o=0.
  - Reset mid-operation discards all entries exactly like a flush.
- Storage: DEPTH-entry register array {inst, addr}. Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- Enqueue condition: fetch_valid_i && fetch_ready_o && !ex_jump_flag_i.
- Dequeue condition: inst_valid_o && !hold_i && !ex_jump_flag_i.
- fetch_ready_o = (count != DEPTH). It is derived from registered state only, with no combinational path from hold_i or fetch_valid_i.
- Full and dequeueing in the same cycle: fetch_ready_o is still 0, so no enqueue occurs (one bubble is accepted).
- Latency: an entry enqueued at edge N appears on inst_o/inst_addr_o after edge N (registered write, combinational head read). There is no same-cycle bypass from fetch_inst_i.
- Simultaneous enqueue and dequeue when non-empty: count is unchanged and both pointers advance.
- Empty: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0. Decode sees a harmless NOP.
- Flush (ex_jump_flag_i=1 at an edge):
  - Pointers and count are cleared.
  - The fetch input offered in that cycle is discarded even if fetch_valid_i=1.
  - Flush overrides both hold_i and enqueue.
  - The cycle after a flush, the stage is empty (NOP) and fetch_ready_o=1.
- hold_i=1 with no flush: head and outputs are stable; enqueue continues until full.
- occupancy_o = count. Invariant: 0 <= count <= DEPTH. Enqueue on full and dequeue on empty are impossible by construction; assertions cover both.

Optional Feature:
- Macro IF_ID_BUF_STATS_EN.
- When defined, two ports are added:
  - flush_cnt_o output 16: counts edges with ex_jump_flag_i=1.
  - bubble_cnt_o output 16: counts edges with inst_valid_o=0, hold_i=0, ex_jump_flag_i=0.
  - Both counters saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- tinyriscv_pkg holds InstBus, InstAddrBus, and a new INST_NOP constant (32'h0000_0013), which is the default for NOP_INST.
- One natural sub-module: if_id_fifo, a generic DEPTH x WIDTH synchronous FIFO with flush, count, full and empty.
- The top-level if_id_buf adds the NOP substitution, flush gating and the optional stats.

Test Plan:
- Reset then idle:
  - inst_valid_o=0, inst_o=32'h13, inst_addr_o=0, fetch_ready_o=1, occupancy_o=0.
- Single enqueue: fetch inst 32'h00500093 @ addr 32'h100, hold_i=0.
  - Next cycle: inst_valid_o=1, inst_o=32'h00500093, inst_addr_o=32'h100.
  - Following cycle: empty, NOP.
- Fill under hold: hold_i=1, offer 3 instructions @ 0x0, 0x4, 0x8.
  - First two accepted; fetch_ready_o=0 and occupancy_o=2.
  - Third stays offered.
  - After release: outputs 0x0, then 0x4, then 0x8 in order.
- Flush with concurrent fetch: 2 entries buffered, ex_jump_flag_i=1 while offering addr 0x20.
  - Next cycle: occupancy_o=0, inst_valid_o=0, fetch_ready_o=1; 0x20 not stored.
- Flush vs hold: hold_i=1 and ex_jump_flag_i=1 together.
  - Buffer is emptied (flush wins).
- Streaming and wrap: 10 back-to-back fetches with hold_i=0.
  - Addresses emerge in order with one-cycle latency; pointers wrap with no loss or duplication.
  - With IF_ID_BUF_STATS_EN defined, flush_cnt_o and bubble_cnt_o match the scoreboard.
